// File: rtl/vproc_mem_responder.sv
// ---------------------------------------------------------------------------
// vproc_mem_responder
//
// Memory-side responder for the vector processor data-memory interface.
// Holds a word-addressed SRAM model, accepts one request per cycle with no
// back-pressure, and returns in-order responses a fixed LATENCY cycles after
// the request. Responses travel through a LATENCY-deep delay line, and the
// outputs come straight from its last register stage.
//
// Parameters:
//   MEM_W      data width in bits (multiple of 8)
//   MEM_WORDS  number of MEM_W-bit words (power of 2, at least 2)
//   BASE_ADDR  byte address of word 0 (aligned to the array size in bytes)
//   LATENCY    request-to-response latency in cycles (1..4)
//
// Ports:
//   clk            system clock
//   rst            synchronous active-high reset
//   mem_req_i      request valid; each high cycle is one request
//   mem_addr_i     byte address
//   mem_we_i       1 = write, 0 = read
//   mem_be_i       byte enables for writes (ignored on reads)
//   mem_wdata_i    write data
//   mem_rvalid_o   response valid
//   mem_err_o      error flag, qualified by mem_rvalid_o
//   mem_rdata_o    read data, qualified by mem_rvalid_o
//   err_count_o    saturating count of error responses issued
// ---------------------------------------------------------------------------
module vproc_mem_responder #(
    parameter int unsigned MEM_W     = 32,
    parameter int unsigned MEM_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned LATENCY   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_req_i,
    input  logic [31:0]          mem_addr_i,
    input  logic                 mem_we_i,
    input  logic [MEM_W/8-1:0]   mem_be_i,
    input  logic [MEM_W-1:0]     mem_wdata_i,
    output logic                 mem_rvalid_o,
    output logic                 mem_err_o,
    output logic [MEM_W-1:0]     mem_rdata_o,
    output logic [15:0]          err_count_o
);

    localparam int          BYTE_W     = int'(MEM_W / 8);
    localparam int          OFF_W      = $clog2(BYTE_W);
    localparam int          IDX_W      = $clog2(MEM_WORDS);
    localparam logic [32:0] MEM_BYTES  = 33'(MEM_WORDS) * 33'(BYTE_W);
    localparam logic [31:0] ALIGN_MASK = 32'(BYTE_W - 1);

    // One delay-line entry. Invalid entries are kept all-zero so that the
    // outputs read 0 on idle cycles without any extra masking.
    typedef struct packed {
        logic             valid;
        logic             err;
        logic [MEM_W-1:0] data;
    } resp_t;

    // ------------------------------------------------------------------
    // Elaboration-time parameter check
    // ------------------------------------------------------------------
    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
        $error("vproc_mem_responder: LATENCY must be within 1..4");
    end

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [31:0]      offset;
    logic             in_range;
    logic             aligned;
    logic             req_bad;
    logic [IDX_W-1:0] word_idx;

    // The offset is taken modulo 2^32, so any address below BASE_ADDR (or
    // wrapping past 0xFFFF_FFFF) lands far above MEM_BYTES and is rejected
    // by one unsigned compare; the index can therefore never alias.
    assign offset   = mem_addr_i - BASE_ADDR;
    assign in_range = ({1'b0, offset} < MEM_BYTES);
    assign aligned  = ((mem_addr_i & ALIGN_MASK) == 32'd0);
    assign req_bad  = !(in_range && aligned);
    assign word_idx = IDX_W'(offset >> OFF_W);

    // ------------------------------------------------------------------
    // Storage array
    // ------------------------------------------------------------------
    logic [MEM_W-1:0] mem [MEM_WORDS];
    logic             wr_en;

    assign wr_en = !rst && mem_req_i && mem_we_i && !req_bad;

    // NOTE: the array has no reset branch on purpose -- contents must
    // survive rst, and a reset would stop it mapping onto an SRAM macro.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < BYTE_W; i++) begin
                if (mem_be_i[i]) begin
                    mem[word_idx][8*i +: 8] <= mem_wdata_i[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Response formation and delay line
    // ------------------------------------------------------------------
    resp_t new_resp;
    resp_t stage_q [LATENCY];
    resp_t stage_d [LATENCY];
    resp_t last_d;

    // NOTE: every combinational output gets a default before any branch, so
    // no path can leave it unassigned and infer a latch.
    always_comb begin
        new_resp = '0;
        if (mem_req_i) begin
            new_resp.valid = 1'b1;
            new_resp.err   = req_bad;
            // Reads sample the array at the request edge; an earlier-cycle
            // write to the same word has already committed by then.
            if (!req_bad && !mem_we_i) begin
                new_resp.data = mem[word_idx];
            end
        end
    end

    always_comb begin
        stage_d[0] = new_resp;
        for (int i = 1; i < LATENCY; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // The entry about to reach the output register this edge.
    assign last_d = stage_d[LATENCY-1];

    logic [15:0] err_count_q;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // stage reads its neighbour's pre-edge value and the line shifts cleanly.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                stage_q[i] <= '0;
            end
            err_count_q <= '0;
        end else begin
            for (int i = 0; i < LATENCY; i++) begin
                stage_q[i] <= stage_d[i];
            end
            // Counted as the error response is issued, not when requested.
            if (last_d.valid && last_d.err && (err_count_q != 16'hFFFF)) begin
                err_count_q <= err_count_q + 16'd1;
            end
        end
    end

    assign mem_rvalid_o = stage_q[LATENCY-1].valid;
    assign mem_err_o    = stage_q[LATENCY-1].err;
    assign mem_rdata_o  = stage_q[LATENCY-1].data;
    assign err_count_o  = err_count_q;

    // ------------------------------------------------------------------
    // Interface assertion
    // ------------------------------------------------------------------
    be_known_on_write: assert property (
        @(posedge clk) disable iff (rst)
        (mem_req_i && mem_we_i) |-> !$isunknown(mem_be_i)
    );

endmodule

// File: tb/tb_vproc_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_vproc_mem_responder
//
// Four responders share one stimulus bus:
//   u_l1: LATENCY=1, BASE 0x0000_0000
//   u_l2: LATENCY=2, BASE 0xFFFF_F000 (array ends exactly at the 32-bit wrap)
//   u_l3: LATENCY=3, BASE 0x0000_0000
//   u_l4: LATENCY=4, BASE 0x0000_0000
// A behavioural model keeps one word array, one expected-response queue and
// one error counter per instance, and every cycle all outputs are compared.
// ---------------------------------------------------------------------------
module tb_vproc_mem_responder;

    localparam int          NI    = 4;
    localparam int          WORDS = 1024;
    localparam int          LAT  [NI] = '{1, 2, 3, 4};
    localparam logic [31:0] BASE [NI] = '{32'h0000_0000, 32'hFFFF_F000,
                                          32'h0000_0000, 32'h0000_0000};

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;

    logic        rvalid [NI];
    logic        err    [NI];
    logic [31:0] rdata  [NI];
    logic [15:0] ecnt   [NI];

    always #5 clk = ~clk;

    vproc_mem_responder #(.MEM_W(32), .MEM_WORDS(WORDS), .BASE_ADDR(BASE[0]), .LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst), .mem_req_i(req), .mem_addr_i(addr), .mem_we_i(we),
        .mem_be_i(be), .mem_wdata_i(wdata), .mem_rvalid_o(rvalid[0]), .mem_err_o(err[0]),
        .mem_rdata_o(rdata[0]), .err_count_o(ecnt[0]));
    vproc_mem_responder #(.MEM_W(32), .MEM_WORDS(WORDS), .BASE_ADDR(BASE[1]), .LATENCY(2)) u_l2 (
        .clk(clk), .rst(rst), .mem_req_i(req), .mem_addr_i(addr), .mem_we_i(we),
        .mem_be_i(be), .mem_wdata_i(wdata), .mem_rvalid_o(rvalid[1]), .mem_err_o(err[1]),
        .mem_rdata_o(rdata[1]), .err_count_o(ecnt[1]));
    vproc_mem_responder #(.MEM_W(32), .MEM_WORDS(WORDS), .BASE_ADDR(BASE[2]), .LATENCY(3)) u_l3 (
        .clk(clk), .rst(rst), .mem_req_i(req), .mem_addr_i(addr), .mem_we_i(we),
        .mem_be_i(be), .mem_wdata_i(wdata), .mem_rvalid_o(rvalid[2]), .mem_err_o(err[2]),
        .mem_rdata_o(rdata[2]), .err_count_o(ecnt[2]));
    vproc_mem_responder #(.MEM_W(32), .MEM_WORDS(WORDS), .BASE_ADDR(BASE[3]), .LATENCY(4)) u_l4 (
        .clk(clk), .rst(rst), .mem_req_i(req), .mem_addr_i(addr), .mem_we_i(we),
        .mem_be_i(be), .mem_wdata_i(wdata), .mem_rvalid_o(rvalid[3]), .mem_err_o(err[3]),
        .mem_rdata_o(rdata[3]), .err_count_o(ecnt[3]));

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct {
        int          due;
        logic        err;
        logic [31:0] data;
    } exp_t;

    logic [31:0] mdl_mem [NI][WORDS];
    exp_t        expq    [NI][$];
    int          mdl_cnt [NI];
    int          cyc   = 0;
    int          tests = 0;
    int          fails = 0;

    // Range check done in 64-bit arithmetic so the wrap case needs no trick.
    function automatic bit mdl_bad(input int n, input logic [31:0] a);
        longint unsigned lo = 64'(BASE[n]);
        longint unsigned hi = lo + 64'(WORDS * 4);
        longint unsigned av = 64'(a);
        return (av < lo) || (av >= hi) || (a[1:0] != 2'b00);
    endfunction

    function automatic int mdl_idx(input int n, input logic [31:0] a);
        return int'((64'(a) - 64'(BASE[n])) / 4);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at the falling edge, update the model at the
    // rising edge, then compare every instance 1 time unit later.
    task automatic step(input bit r, input bit q, input logic [31:0] a, input bit w,
                        input logic [3:0] b, input logic [31:0] d);
        exp_t        e;
        logic        ev;
        logic        ee;
        logic [31:0] ed;
        int          ix;
        @(negedge clk);
        rst = r; req = q; addr = a; we = w; be = b; wdata = d;
        @(posedge clk);
        cyc++;
        for (int n = 0; n < NI; n++) begin
            if (r) begin
                expq[n].delete();
                mdl_cnt[n] = 0;
            end else if (q) begin
                e.due  = cyc + LAT[n] - 1;
                e.err  = mdl_bad(n, a);
                e.data = 32'h0;
                if (!e.err) begin
                    ix = mdl_idx(n, a);
                    if (w) begin
                        for (int k = 0; k < 4; k++)
                            if (b[k]) mdl_mem[n][ix][8*k +: 8] = d[8*k +: 8];
                    end else begin
                        e.data = mdl_mem[n][ix];
                    end
                end
                expq[n].push_back(e);
            end
        end
        #1;
        for (int n = 0; n < NI; n++) begin
            ev = 1'b0; ee = 1'b0; ed = 32'h0;
            if (expq[n].size() > 0 && expq[n][0].due == cyc) begin
                e  = expq[n].pop_front();
                ev = 1'b1; ee = e.err; ed = e.data;
                if (ee && mdl_cnt[n] < 32'hFFFF) mdl_cnt[n]++;
            end
            check($sformatf("L%0d c%0d rvalid", LAT[n], cyc), 32'(rvalid[n]), 32'(ev));
            check($sformatf("L%0d c%0d err", LAT[n], cyc), 32'(err[n]), 32'(ee));
            check($sformatf("L%0d c%0d rdata", LAT[n], cyc), rdata[n], ed);
            check($sformatf("L%0d c%0d err_count", LAT[n], cyc), 32'(ecnt[n]), 32'(mdl_cnt[n]));
        end
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(0, 0, 32'h0, 0, 4'h0, 32'h0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
        step(0, 1, a, 1, b, d);
    endtask

    task automatic rd(input logic [31:0] a);
        step(0, 1, a, 0, 4'h0, 32'h0);
    endtask

    // ------------------------------------------------------------------
    // Directed and randomized stimulus
    // ------------------------------------------------------------------
    logic [31:0] ra;
    bit          rq;
    bit          rw;
    int          kind;

    initial begin
        rst = 1'b1; req = 1'b0; addr = '0; we = 1'b0; be = '0; wdata = '0;
        for (int n = 0; n < NI; n++) mdl_cnt[n] = 0;

        // Reset: outputs and counters clear.
        step(1, 0, 32'h0, 0, 4'h0, 32'h0);
        step(1, 1, 32'h0, 1, 4'hF, 32'h1234_5678);  // request ignored under reset
        idle(2);

        // Preload low region (words 0..63 and the last word).
        for (int i = 0; i < 64; i++) wr(32'(i * 4), 4'hF, $urandom);
        wr(32'h0000_0FFC, 4'hF, $urandom);
        idle(4);

        // Write then read the same word on the next cycle.
        wr(32'h0000_0010, 4'hF, 32'hDEAD_BEEF);
        rd(32'h0000_0010);
        check("raw_readback", rdata[0], 32'hDEAD_BEEF);

        // Partial write over a known word.
        wr(32'h0000_0020, 4'hF, 32'hAAAA_AAAA);
        wr(32'h0000_0020, 4'b0101, 32'h1122_3344);
        rd(32'h0000_0020);
        check("partial_write", rdata[0], 32'hAA22_AA44);

        // No-op write with be=0.
        wr(32'h0000_0024, 4'h0, 32'hFFFF_FFFF);
        idle(4);

        // Eight back-to-back reads of words 0..7.
        for (int i = 0; i < 8; i++) rd(32'(i * 4));
        idle(5);

        // Error cases from a freshly reset counter.
        step(1, 0, 32'h0, 0, 4'h0, 32'h0);
        rd(32'h0000_1000);
        check("oob_err", 32'(err[0]), 32'd1);
        check("oob_rdata", rdata[0], 32'h0);
        check("oob_count", 32'(ecnt[0]), 32'd1);
        wr(32'h0000_0002, 4'hF, 32'h5555_5555);
        check("misalign_err", 32'(err[0]), 32'd1);
        check("misalign_count", 32'(ecnt[0]), 32'd2);
        rd(32'h0000_0000);
        idle(5);

        // Preload the high region that ends at the 32-bit wrap.
        for (int i = 0; i < 64; i++) wr(32'hFFFF_F000 + 32'(i * 4), 4'hF, $urandom);
        wr(32'hFFFF_FFFC, 4'hF, $urandom);
        idle(5);

        // Reset while reads are in flight; earlier write must persist.
        wr(32'h0000_0030, 4'hF, 32'hCAFE_F00D);
        rd(32'h0000_0004);
        rd(32'h0000_0008);
        step(1, 1, 32'h0000_000C, 0, 4'h0, 32'h0);
        idle(6);
        rd(32'h0000_0030);
        check("post_reset_data", rdata[0], 32'hCAFE_F00D);
        idle(4);

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            rq   = ($urandom_range(0, 9) < 7);
            rw   = ($urandom_range(0, 1) == 1);
            kind = $urandom_range(0, 4);
            case (kind)
                0: ra = 32'($urandom_range(0, 63)) << 2;
                1: ra = 32'hFFFF_F000 + (32'($urandom_range(0, 63)) << 2);
                2: ra = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3));
                3: begin
                    case ($urandom_range(0, 4))
                        0: ra = 32'h0000_1000;
                        1: ra = 32'h0000_0FFC;
                        2: ra = 32'hFFFF_FFFC;
                        3: ra = 32'hFFFF_EFFC;
                        default: ra = 32'h0000_0000;
                    endcase
                end
                default: ra = ($urandom & 32'h7FFF_FFFF) | 32'h0010_0000;
            endcase
            step(0, rq, ra, rw, 4'($urandom_range(0, 15)), $urandom);
        end
        idle(6);

        // Saturation of the error counter.
        force u_l1.err_count_q = 16'hFFFE;
        force u_l2.err_count_q = 16'hFFFE;
        force u_l3.err_count_q = 16'hFFFE;
        force u_l4.err_count_q = 16'hFFFE;
        #1;
        release u_l1.err_count_q;
        release u_l2.err_count_q;
        release u_l3.err_count_q;
        release u_l4.err_count_q;
        for (int n = 0; n < NI; n++) mdl_cnt[n] = 32'hFFFE;
        rd(32'h0000_1000);
        rd(32'h0000_1000);
        rd(32'h0000_1000);
        idle(5);
        check("sat_count_l1", 32'(ecnt[0]), 32'h0000_FFFF);
        check("sat_count_l4", 32'(ecnt[3]), 32'h0000_FFFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
